// File: rtl/alu_dispatch_pkg.sv
// alu_dispatch_pkg: shared types and constants for the ALU dispatcher.
//   - state_e    : dispatcher FSM states (IDLE, ISSUE, WAIT, RESP)
//   - F3_*       : RISC-V funct3 codes of the integer ALU ops
//   - XLEN       : datapath width
//   - REG_IDX_W  : register index width
//   - imm_fun7() : funct7 presented to the ALU for an I-type op
package alu_dispatch_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_SLTU   = 3'b011;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_SRLA   = 3'b101;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  // Shift-immediates carry their funct7 in imm[11:5] (SRAI vs SRLI);
  // every other I-type op gets 0 so ADDI can never turn into a subtract.
  function automatic logic [6:0] imm_fun7(input logic [2:0] fun3,
                                          input logic [6:0] imm_hi);
    logic [6:0] f7;
    case (fun3)
      F3_SLL:  f7 = imm_hi;
      F3_SRLA: f7 = imm_hi;
      default: f7 = 7'd0;
    endcase
    return f7;
  endfunction

endpackage

// File: rtl/alu_dispatch_if.sv
// alu_dispatch_if: op-issue and writeback handshake bundle of the dispatcher.
//   issue side    : in_valid/in_ready, in_fun7, in_fun3, in_rs1_val, in_rs2_val,
//                   in_rs1_idx, in_rs2_idx, in_rd, in_use_imm, in_imm
//   writeback side: out_valid/out_ready, out_rd, out_data, out_zero, out_neg
//   master modport: the decoder/writeback environment; slave: the dispatcher.
interface alu_dispatch_if;
  import alu_dispatch_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [6:0]           in_fun7;
  logic [2:0]           in_fun3;
  logic [XLEN-1:0]      in_rs1_val;
  logic [XLEN-1:0]      in_rs2_val;
  logic [REG_IDX_W-1:0] in_rs1_idx;
  logic [REG_IDX_W-1:0] in_rs2_idx;
  logic [REG_IDX_W-1:0] in_rd;
  logic                 in_use_imm;
  logic [XLEN-1:0]      in_imm;

  logic                 out_valid;
  logic                 out_ready;
  logic [REG_IDX_W-1:0] out_rd;
  logic [XLEN-1:0]      out_data;
  logic                 out_zero;
  logic                 out_neg;

  modport master (
    output in_valid, in_fun7, in_fun3, in_rs1_val, in_rs2_val,
           in_rs1_idx, in_rs2_idx, in_rd, in_use_imm, in_imm, out_ready,
    input  in_ready, out_valid, out_rd, out_data, out_zero, out_neg
  );

  modport slave (
    input  in_valid, in_fun7, in_fun3, in_rs1_val, in_rs2_val,
           in_rs1_idx, in_rs2_idx, in_rd, in_use_imm, in_imm, out_ready,
    output in_ready, out_valid, out_rd, out_data, out_zero, out_neg
  );

endinterface

// File: rtl/alu_dispatch_fwd.sv
// alu_dispatch_fwd: forward register holding the last completed result with
// rd != 0, plus the operand mux that substitutes it for stale register-file
// values at transfer time. Only built when ALU_DISPATCH_FWD_EN is defined.
//   clk, reset (async, active low)
//   upd_en/upd_rd/upd_data : result capture from the dispatcher
//   use_imm                : rs2 is an immediate, never forwarded
//   rs*_idx/rs*_val        : incoming operand indices and values
//   rs1_fwd/rs2_fwd        : operand values after forwarding
module alu_dispatch_fwd
  import alu_dispatch_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 upd_en,
  input  logic [REG_IDX_W-1:0] upd_rd,
  input  logic [XLEN-1:0]      upd_data,
  input  logic                 use_imm,
  input  logic [REG_IDX_W-1:0] rs1_idx,
  input  logic [REG_IDX_W-1:0] rs2_idx,
  input  logic [XLEN-1:0]      rs1_val,
  input  logic [XLEN-1:0]      rs2_val,
  output logic [XLEN-1:0]      rs1_fwd,
  output logic [XLEN-1:0]      rs2_fwd
);

  logic                 fwd_vld_q, fwd_vld_d;
  logic [REG_IDX_W-1:0] fwd_rd_q, fwd_rd_d;
  logic [XLEN-1:0]      fwd_data_q, fwd_data_d;

  // Forward register state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fwd_vld_q  <= 1'b0;
      fwd_rd_q   <= {REG_IDX_W{1'b0}};
      fwd_data_q <= {XLEN{1'b0}};
    end else begin
      fwd_vld_q  <= fwd_vld_d;
      fwd_rd_q   <= fwd_rd_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  // Writes to x0 are never kept, so index 0 can never match a forward
  always_comb begin
    fwd_vld_d  = fwd_vld_q;
    fwd_rd_d   = fwd_rd_q;
    fwd_data_d = fwd_data_q;
    if (upd_en && (upd_rd != {REG_IDX_W{1'b0}})) begin
      fwd_vld_d  = 1'b1;
      fwd_rd_d   = upd_rd;
      fwd_data_d = upd_data;
    end else begin
      fwd_vld_d  = fwd_vld_q;
    end
  end

  // Operand substitution
  always_comb begin
    rs1_fwd = rs1_val;
    rs2_fwd = rs2_val;
    if (fwd_vld_q && (rs1_idx == fwd_rd_q)) begin
      rs1_fwd = fwd_data_q;
    end else begin
      rs1_fwd = rs1_val;
    end
    if (fwd_vld_q && !use_imm && (rs2_idx == fwd_rd_q)) begin
      rs2_fwd = fwd_data_q;
    end else begin
      rs2_fwd = rs2_val;
    end
  end

endmodule

// File: rtl/alu_dispatch.sv
// alu_dispatch: accepts one decoded ALU op, launches it on an external ALU,
// waits for completion and offers the result on a writeback handshake.
//   clk, reset (async, active low)
//   bus       : alu_dispatch_if.slave (issue + writeback handshakes)
//   alu_start/alu_fun7/alu_fun3/alu_rs1/alu_rs2 : to the ALU
//   alu_res/alu_zero/alu_neg/alu_busy           : from the ALU
// Optional feature: define ALU_DISPATCH_FWD_EN to forward the last completed
// result into matching source operands (alu_dispatch_fwd).
module alu_dispatch
  import alu_dispatch_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  alu_dispatch_if.slave   bus,
  output logic            alu_start,
  output logic [6:0]      alu_fun7,
  output logic [2:0]      alu_fun3,
  output logic [XLEN-1:0] alu_rs1,
  output logic [XLEN-1:0] alu_rs2,
  input  logic [XLEN-1:0] alu_res,
  input  logic            alu_zero,
  input  logic            alu_neg,
  input  logic            alu_busy
);

  state_e               state_q, state_d;
  logic [6:0]           fun7_q, fun7_d;
  logic [2:0]           fun3_q, fun3_d;
  logic [XLEN-1:0]      rs1_q, rs1_d;
  logic [XLEN-1:0]      rs2_q, rs2_d;
  logic [REG_IDX_W-1:0] rd_q, rd_d;
  logic [REG_IDX_W-1:0] out_rd_q, out_rd_d;
  logic [XLEN-1:0]      out_data_q, out_data_d;
  logic                 out_zero_q, out_zero_d;
  logic                 out_neg_q, out_neg_d;
  logic                 cap_en_s;
  logic [XLEN-1:0]      op_a_s, op_b_s;

  // Zero flag is recomputed locally from the (x0-masked) data
  logic unused_alu_zero_s;
  assign unused_alu_zero_s = alu_zero;

`ifdef ALU_DISPATCH_FWD_EN
  alu_dispatch_fwd u_fwd (
    .clk      (clk),
    .reset    (reset),
    .upd_en   (cap_en_s),
    .upd_rd   (rd_q),
    .upd_data (alu_res),
    .use_imm  (bus.in_use_imm),
    .rs1_idx  (bus.in_rs1_idx),
    .rs2_idx  (bus.in_rs2_idx),
    .rs1_val  (bus.in_rs1_val),
    .rs2_val  (bus.in_rs2_val),
    .rs1_fwd  (op_a_s),
    .rs2_fwd  (op_b_s)
  );
`else
  logic unused_idx_s;
  assign unused_idx_s = ^{bus.in_rs1_idx, bus.in_rs2_idx};
  assign op_a_s = bus.in_rs1_val;
  assign op_b_s = bus.in_rs2_val;
`endif

  // FSM state, latched op and captured result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      fun7_q     <= 7'd0;
      fun3_q     <= 3'd0;
      rs1_q      <= {XLEN{1'b0}};
      rs2_q      <= {XLEN{1'b0}};
      rd_q       <= {REG_IDX_W{1'b0}};
      out_rd_q   <= {REG_IDX_W{1'b0}};
      out_data_q <= {XLEN{1'b0}};
      out_zero_q <= 1'b0;
      out_neg_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fun7_q     <= fun7_d;
      fun3_q     <= fun3_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      out_rd_q   <= out_rd_d;
      out_data_q <= out_data_d;
      out_zero_q <= out_zero_d;
      out_neg_q  <= out_neg_d;
    end
  end

  // Next state, op latch on transfer and result capture on ALU completion
  always_comb begin
    state_d    = state_q;
    fun7_d     = fun7_q;
    fun3_d     = fun3_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    out_rd_d   = out_rd_q;
    out_data_d = out_data_q;
    out_zero_d = out_zero_q;
    out_neg_d  = out_neg_q;
    cap_en_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_d = ST_ISSUE;
          fun3_d  = bus.in_fun3;
          rd_d    = bus.in_rd;
          rs1_d   = op_a_s;
          if (bus.in_use_imm) begin
            fun7_d = imm_fun7(bus.in_fun3, bus.in_imm[11:5]);
            rs2_d  = bus.in_imm;
          end else begin
            fun7_d = bus.in_fun7;
            rs2_d  = op_b_s;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!alu_busy) begin
          state_d  = ST_RESP;
          cap_en_s = 1'b1;
          out_rd_d = rd_q;
          // x0 is hard-wired: its result is discarded and reads as zero
          if (rd_q == {REG_IDX_W{1'b0}}) begin
            out_data_d = {XLEN{1'b0}};
            out_neg_d  = 1'b0;
          end else begin
            out_data_d = alu_res;
            out_neg_d  = alu_neg;
          end
          out_zero_d = (out_data_d == {XLEN{1'b0}});
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_RESP);
  assign bus.out_rd    = out_rd_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_zero  = out_zero_q;
  assign bus.out_neg   = out_neg_q;

  assign alu_start = (state_q == ST_ISSUE);
  assign alu_fun7  = fun7_q;
  assign alu_fun3  = fun3_q;
  assign alu_rs1   = rs1_q;
  assign alu_rs2   = rs2_q;

endmodule
